mem_modport: RTL and testbench

//   Single-port synchronous RAM, 32 words x 8 bits, the memory-side endpoint of the mem_interf bus.
//   The testbench drives read/write/addr/data_in on the falling clock edge.
//   The RAM acts on the rising edge and presents read data on data_out.

---
 rtl/mem_modport.sv | 36 +++
 tb/tb_mem_modport.sv | 112 +++++++++++
 2 files changed

// File: rtl/mem_modport.sv
// mem_modport: 32x8 single-port synchronous RAM with registered, read-before-write output
module mem_modport #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    always_comb begin
        mem_d = mem_q;
        if (write) mem_d[addr] = data_in;
        data_out_d = read ? mem_q[addr] : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            data_out_q <= '0;
        end else begin
            mem_q      <= mem_d;
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
endmodule

// File: tb/tb_mem_modport.sv
// tb_mem_modport: directed scoreboard bench for mem_modport
module tb_mem_modport;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [4:0] addr = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;

    typedef struct {
        logic [4:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   failed = 0;
    logic rd_edge = 1'b0;

    mem_modport dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write),
        .addr(addr), .data_in(data_in), .data_out(data_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic op(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        read = r;
        write = w;
        addr = a;
        data_in = d;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e);
        exp_t x;
        op(1'b1, 1'b0, a, 8'h00);
        x.a = a;
        x.d = e;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) rd_edge = read && rst_n;

    always @(negedge clk) begin
        exp_t x;
        if (rd_edge) begin
            rd_edge = 1'b0;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_read: got %h expected none", data_out);
            end else begin
                x = exp_q.pop_front();
                chk($sformatf("read_addr_%0d", x.a), data_out, x.d);
            end
        end
    end

    initial begin
        exp_t x;
        #2 rst_n = 1'b0;
        #1 chk("reset_data_out", data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) rd(5'(i), 8'h00);
        op(1'b0, 1'b1, 5'd5, 8'hA5);
        rd(5'd5, 8'hA5);
        for (int i = 0; i < 32; i++) op(1'b0, 1'b1, 5'(i), 8'(i) + 8'h40);
        for (int i = 31; i >= 0; i--) rd(5'(i), 8'(i) + 8'h40);
        rd(5'd3, 8'h43);
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 1'b0, 5'(i * 7 + 1), 8'(i * 37 + 11));
            @(posedge clk);
            #1 chk($sformatf("hold_cycle_%0d", i), data_out, 8'h43);
        end
        op(1'b1, 1'b1, 5'd7, 8'h3C);
        x.a = 5'd7;
        x.d = 8'h47;
        exp_q.push_back(x);
        rd(5'd7, 8'h3C);
        op(1'b0, 1'b1, 5'd9, 8'hFF);
        rd(5'd9, 8'hFF);
        op(1'b0, 1'b0, 5'd0, 8'h00);
        #2 rst_n = 1'b0;
        #1 chk("midop_reset_data_out", data_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        rd(5'd9, 8'h00);
        rd(5'd5, 8'h00);
        op(1'b0, 1'b0, 5'd0, 8'h00);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
